// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data plus the instruction handoff and redirect/stall controls from decode.
// master = fetch stage, slave = the ROM/decode side that surrounds it.
interface instr_fetch_if;
   logic [23:0] rom_addr;
   logic [23:0] rom_data;
   logic        stall;
   logic        branch_taken;
   logic [23:0] branch_target;
   logic [23:0] instr;
   logic [23:0] instr_pc;
   logic        instr_valid;
   logic        halted;

   modport master (
      output rom_addr,
      input  rom_data,
      input  stall,
      input  branch_taken,
      input  branch_target,
      output instr,
      output instr_pc,
      output instr_valid,
      output halted
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      output stall,
      output branch_taken,
      output branch_target,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      input  halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC drives ROM address, word registered into IR one cycle later; stall holds, branch flushes.
// IF_HALT_DETECT_EN: opcode 4'b1101 freezes fetch until reset; otherwise halted is tied to 0.
module instr_fetch #(
   parameter int unsigned ROM_DEPTH = 128,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master bus
);
   localparam int AW = $clog2(ROM_DEPTH);

   logic [AW-1:0] pc;
   logic [23:0]   instr_r;
   logic [23:0]   instr_pc_r;
   logic          instr_valid_r;
   logic          halted_r;
   logic          halt_word;

`ifdef IF_HALT_DETECT_EN
   assign halt_word  = (bus.rom_data[23:20] == 4'b1101);
   assign bus.halted = halted_r;
`else
   assign halt_word  = 1'b0;
   assign bus.halted = 1'b0;
`endif

   assign bus.rom_addr    = 24'(pc);
   assign bus.instr       = instr_r;
   assign bus.instr_pc    = instr_pc_r;
   assign bus.instr_valid = instr_valid_r;

   // Redirect targets only need the low AW bits; the rest is don't-care.
   generate
      if (AW < 24) begin : g_tgt_unused
         logic unused_tgt_hi;
         assign unused_tgt_hi = ^bus.branch_target[23:AW];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= AW'(RESET_PC);
         instr_r       <= '0;
         instr_pc_r    <= '0;
         instr_valid_r <= 1'b0;
         halted_r      <= 1'b0;
      end else if (halted_r) begin
         instr_valid_r <= 1'b0;
      end else if (bus.branch_taken) begin
         // The word currently on rom_data is wrong-path and is dropped.
         pc            <= bus.branch_target[AW-1:0];
         instr_valid_r <= 1'b0;
      end else if (!bus.stall) begin
         instr_r       <= bus.rom_data;
         instr_pc_r    <= 24'(pc);
         instr_valid_r <= 1'b1;
         if (halt_word) begin
            halted_r <= 1'b1;
         end else begin
            pc <= pc + AW'(1);
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for sequencing/branch/stall/wrap, hand sequences for HALT and reset.
module tb_instr_fetch;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   instr_fetch_if bus ();

   instr_fetch #(.ROM_DEPTH(128), .RESET_PC(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [23:0] romw(int i);
      logic [7:0] a;
      a = 8'(i);
      if (i == 97) return 24'hD00000;
      return {8'h20, a, ~a};
   endfunction

   logic [23:0] rom [128];
   assign bus.rom_data = rom[bus.rom_addr[6:0]];

   typedef struct {
      logic        st;
      logic        br;
      logic [23:0] tgt;
      logic [23:0] e_instr;
      logic [23:0] e_pc;
      logic        e_vld;
      logic [23:0] e_addr;
   } vec_t;

   function automatic vec_t mk(logic st, logic br, logic [23:0] tgt,
                               logic [23:0] e_instr, logic [23:0] e_pc,
                               logic e_vld, logic [23:0] e_addr);
      vec_t v;
      v.st = st; v.br = br; v.tgt = tgt;
      v.e_instr = e_instr; v.e_pc = e_pc; v.e_vld = e_vld; v.e_addr = e_addr;
      return v;
   endfunction

   task automatic chk(string name, logic [23:0] act, logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [23:0] e_instr, logic [23:0] e_pc,
                          logic e_vld, logic e_halt, logic [23:0] e_addr);
      chk({tag, ".instr"},       bus.instr,              e_instr);
      chk({tag, ".instr_pc"},    bus.instr_pc,           e_pc);
      chk({tag, ".instr_valid"}, 24'(bus.instr_valid),   24'(e_vld));
      chk({tag, ".halted"},      24'(bus.halted),        24'(e_halt));
      chk({tag, ".rom_addr"},    bus.rom_addr,           e_addr);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic st, logic br, logic [23:0] tgt);
      bus.stall         = st;
      bus.branch_taken  = br;
      bus.branch_target = tgt;
   endtask

   vec_t vecs [22];
   logic hd;

   initial begin
`ifdef IF_HALT_DETECT_EN
      hd = 1'b1;
`else
      hd = 1'b0;
`endif
      for (int i = 0; i < 128; i++) rom[i] = romw(i);

      //            st br tgt         instr        pc      vld addr
      vecs[0]  = mk(0, 0, 24'h0,      romw(0),   24'd0,   1, 24'd1);
      vecs[1]  = mk(0, 0, 24'h0,      romw(1),   24'd1,   1, 24'd2);
      vecs[2]  = mk(0, 0, 24'h0,      romw(2),   24'd2,   1, 24'd3);
      vecs[3]  = mk(0, 0, 24'h0,      romw(3),   24'd3,   1, 24'd4);
      vecs[4]  = mk(0, 1, 24'h000049, romw(3),   24'd3,   0, 24'd73);
      vecs[5]  = mk(0, 0, 24'h0,      romw(73),  24'd73,  1, 24'd74);
      vecs[6]  = mk(0, 1, 24'h0000C9, romw(73),  24'd73,  0, 24'd73);
      vecs[7]  = mk(0, 0, 24'h0,      romw(73),  24'd73,  1, 24'd74);
      vecs[8]  = mk(1, 1, 24'hFFFF05, romw(73),  24'd73,  0, 24'd5);
      vecs[9]  = mk(0, 0, 24'h0,      romw(5),   24'd5,   1, 24'd6);
      vecs[10] = mk(1, 0, 24'h0,      romw(5),   24'd5,   1, 24'd6);
      vecs[11] = mk(1, 0, 24'h0,      romw(5),   24'd5,   1, 24'd6);
      vecs[12] = mk(1, 0, 24'h0,      romw(5),   24'd5,   1, 24'd6);
      vecs[13] = mk(0, 0, 24'h0,      romw(6),   24'd6,   1, 24'd7);
      vecs[14] = mk(0, 1, 24'd126,    romw(6),   24'd6,   0, 24'd126);
      vecs[15] = mk(0, 0, 24'h0,      romw(126), 24'd126, 1, 24'd127);
      vecs[16] = mk(0, 0, 24'h0,      romw(127), 24'd127, 1, 24'd0);
      vecs[17] = mk(0, 0, 24'h0,      romw(0),   24'd0,   1, 24'd1);
      vecs[18] = mk(0, 0, 24'h0,      romw(1),   24'd1,   1, 24'd2);
      vecs[19] = mk(0, 1, 24'd10,     romw(1),   24'd1,   0, 24'd10);
      vecs[20] = mk(1, 0, 24'h0,      romw(1),   24'd1,   0, 24'd10);
      vecs[21] = mk(0, 0, 24'h0,      romw(10),  24'd10,  1, 24'd11);

      reset = 1'b1;
      drive(0, 0, 24'h0);
      step();
      step();
      reset = 1'b0;
      chk_all("reset", 24'h0, 24'h0, 0, 0, 24'h0);

      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].st, vecs[i].br, vecs[i].tgt);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc,
                 vecs[i].e_vld, 0, vecs[i].e_addr);
      end

      // Branch coinciding with the HALT word on rom_data: branch wins.
      drive(0, 1, 24'd97);
      step();
      chk_all("bh_to97", romw(10), 24'd10, 0, 0, 24'd97);
      drive(0, 1, 24'd20);
      step();
      chk_all("bh_redir", romw(10), 24'd10, 0, 0, 24'd20);
      drive(0, 0, 24'h0);
      step();
      chk_all("bh_fetch", romw(20), 24'd20, 1, 0, 24'd21);

      // HALT word fetched in normal flow.
      drive(0, 1, 24'd96);
      step();
      drive(0, 0, 24'h0);
      step();
      chk_all("h_96", romw(96), 24'd96, 1, 0, 24'd97);
      step();
      chk_all("h_cap", 24'hD00000, 24'd97, 1, hd, hd ? 24'd97 : 24'd98);
      step();
      if (hd) chk_all("h_frz", 24'hD00000, 24'd97, 0, 1, 24'd97);
      else    chk_all("h_run", romw(98), 24'd98, 1, 0, 24'd99);
      drive(0, 1, 24'd5);
      step();
      if (hd) chk_all("h_br1", 24'hD00000, 24'd97, 0, 1, 24'd97);
      else    chk_all("h_br1", romw(98), 24'd98, 0, 0, 24'd5);
      drive(1, 1, 24'd40);
      step();
      if (hd) chk_all("h_br2", 24'hD00000, 24'd97, 0, 1, 24'd97);
      else    chk_all("h_br2", romw(98), 24'd98, 0, 0, 24'd40);
      drive(0, 0, 24'h0);

      // Reset while halted (or running, without the feature).
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_all("rst2", 24'h0, 24'h0, 0, 0, 24'h0);
      step();
      chk_all("rst2_fetch", romw(0), 24'd0, 1, 0, 24'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
